slide_merge: RTL and testbench

Move engine for the 2048 datapath. It takes a captured 4x4 board and a move direction, then slides and merges one line per clock. It returns the resulting board, a moved flag and the score increment. Its output board is the one handed to `pop_random` for new-tile insertion. It is the consumer-side counterpart of `pop_random`: it empties and merges cells, and `pop_random` fills them.

---
 rtl/slide_merge.sv | 170 +++++++++++++++++
 tb/tb_slide_merge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/slide_merge.sv
// slide_merge: 2048 move engine. Latches a 4x4 board and a direction, then
// slides and merges one line per clock (4 cycles), and reports the result
// board, a moved flag and the score gained from merges.
module slide_merge #(
   parameter int W  = 16,
   parameter int SW = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    dir,
   input  logic [W-1:0]  matrix_in  [0:3][0:3],
   output logic          busy,
   output logic          done,
   output logic          moved,
   output logic [SW-1:0] score_add,
   output logic [W-1:0]  matrix_out [0:3][0:3]
);

   typedef enum logic {IDLE = 1'b0, PROC = 1'b1} state_t;

   // Largest tile; it never merges so a merge can never overflow W bits.
   localparam logic [W-1:0] MAXV = {1'b1, {(W-1){1'b0}}};

   state_t        state;
   logic [1:0]    ln;
   logic [1:0]    d;
   logic [W-1:0]  src [0:3][0:3];
   logic [W-1:0]  res [0:3][0:3];
   logic [SW-1:0] score;

   logic [1:0]    row_idx [0:3];
   logic [1:0]    col_idx [0:3];
   logic [W-1:0]  c0 [0:3];
   logic [W-1:0]  c1 [0:3];
   logic [W-1:0]  c2 [0:3];
   logic [W-1:0]  c3 [0:3];
   logic [1:0]    k1;
   logic [1:0]    k3;
   logic [SW-1:0] line_score;
   logic [SW-1:0] score_next;
   logic [W-1:0]  res_next [0:3][0:3];
   logic          differs;

   // Map line position j of the current line to board coordinates, c[0] at the leading edge.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         row_idx[j] = ln;
         col_idx[j] = 2'(j);
         case (d)
            2'd0: begin row_idx[j] = ln;            col_idx[j] = 2'(j);         end
            2'd1: begin row_idx[j] = ln;            col_idx[j] = 2'd3 - 2'(j);  end
            2'd2: begin row_idx[j] = 2'(j);         col_idx[j] = ln;            end
            2'd3: begin row_idx[j] = 2'd3 - 2'(j);  col_idx[j] = ln;            end
            default: begin row_idx[j] = ln;         col_idx[j] = 2'(j);         end
         endcase
      end
   end

   // Extract, compact, merge once per pair, compact again; accumulate merge score.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         c0[j] = src[row_idx[j]][col_idx[j]];
         c1[j] = {W{1'b0}};
         c3[j] = {W{1'b0}};
      end
      k1 = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (c0[i] != {W{1'b0}}) begin
            c1[k1] = c0[i];
            k1     = k1 + 2'd1;
         end else begin
            k1 = k1;
         end
      end
      // Zeroing the consumed partner prevents it from merging again.
      for (int i = 0; i < 4; i++) c2[i] = c1[i];
      line_score = {SW{1'b0}};
      for (int i = 0; i < 3; i++) begin
         if ((c2[i] != {W{1'b0}}) && (c2[i] == c2[i+1]) && (c2[i] != MAXV)) begin
            c2[i]      = c2[i] << 1;
            c2[i+1]    = {W{1'b0}};
            line_score = line_score + SW'(c2[i]);
         end else begin
            line_score = line_score;
         end
      end
      k3 = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (c2[i] != {W{1'b0}}) begin
            c3[k3] = c2[i];
            k3     = k3 + 2'd1;
         end else begin
            k3 = k3;
         end
      end
      score_next = score + line_score;
   end

   // Result board with the current line written back, and comparison against the source.
   always_comb begin
      res_next = res;
      for (int j = 0; j < 4; j++) begin
         res_next[row_idx[j]][col_idx[j]] = c3[j];
      end
      differs = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (res_next[r][c] != src[r][c]) differs = 1'b1;
            else                             differs = differs;
         end
      end
   end

   // Control FSM, working registers and registered result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ln        <= 2'd0;
         d         <= 2'd0;
         score     <= {SW{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         moved     <= 1'b0;
         score_add <= {SW{1'b0}};
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               src[r][c]        <= {W{1'b0}};
               res[r][c]        <= {W{1'b0}};
               matrix_out[r][c] <= {W{1'b0}};
            end
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src   <= matrix_in;
                  d     <= dir;
                  score <= {SW{1'b0}};
                  ln    <= 2'd0;
                  busy  <= 1'b1;
                  state <= PROC;
               end
            end
            PROC: begin
               res   <= res_next;
               score <= score_next;
               if (ln == 2'd3) begin
                  matrix_out <= res_next;
                  moved      <= differs;
                  score_add  <= score_next;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  ln         <= 2'd0;
                  state      <= IDLE;
               end else begin
                  ln <= ln + 2'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               ln    <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slide_merge.sv
// Directed testbench for slide_merge: one task per scenario, inline checks.
module tb_slide_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  dir;
   logic [15:0] mat  [0:3][0:3];
   logic        busy;
   logic        done;
   logic        moved;
   logic [19:0] score_add;
   logic [15:0] mout [0:3][0:3];
   logic [15:0] exp_b [0:3][0:3];

   int checks = 0;
   int errors = 0;
   int lat;

   slide_merge #(.W(16), .SW(20)) dut (
      .clk(clk), .reset(reset), .start(start), .dir(dir),
      .matrix_in(mat), .busy(busy), .done(done), .moved(moved),
      .score_add(score_add), .matrix_out(mout)
   );

   always #5 clk = ~clk;

   task automatic clear_boards();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            mat[r][c]   = 16'd0;
            exp_b[r][c] = 16'd0;
         end
   endtask

   // Number of matrix_out cells differing from exp_b.
   function automatic int board_diff();
      int n = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (mout[r][c] !== exp_b[r][c]) n++;
      return n;
   endfunction

   // Start a move with the current mat; lat = edges after the accepting edge until done (20 = timeout).
   task automatic run_move(input logic [1:0] dr, output int l);
      @(negedge clk);
      dir = dr; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      l = 0;
      while (done !== 1'b1 && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b want 0", moved); end
      checks++; if (score_add !== 20'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score_add); end
      clear_boards();
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL reset_board: %0d cells differ from 0", board_diff()); end
   endtask

   task automatic test_left_pairs();
      clear_boards();
      mat[0][0] = 16'd2; mat[0][1] = 16'd2; mat[0][2] = 16'd4; mat[0][3] = 16'd4;
      exp_b[0][0] = 16'd4; exp_b[0][1] = 16'd8;
      run_move(2'd0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL left_pairs_latency: got %0d want 4", lat); end
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL left_pairs_board: %0d cells wrong, row0=%0d,%0d,%0d,%0d want 4,8,0,0", board_diff(), mout[0][0], mout[0][1], mout[0][2], mout[0][3]); end
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL left_pairs_moved: got %b want 1", moved); end
      checks++; if (score_add !== 20'd12) begin errors++; $display("FAIL left_pairs_score: got %0d want 12", score_add); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
   endtask

   task automatic test_left_four();
      clear_boards();
      for (int c = 0; c < 4; c++) mat[1][c] = 16'd2;
      exp_b[1][0] = 16'd4; exp_b[1][1] = 16'd4;
      run_move(2'd0, lat);
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL left_four_board: row1=%0d,%0d,%0d,%0d want 4,4,0,0", mout[1][0], mout[1][1], mout[1][2], mout[1][3]); end
      checks++; if (score_add !== 20'd8) begin errors++; $display("FAIL left_four_score: got %0d want 8", score_add); end
   endtask

   task automatic test_right();
      clear_boards();
      mat[2][0] = 16'd2; mat[2][2] = 16'd2; mat[2][3] = 16'd4;
      exp_b[2][2] = 16'd4; exp_b[2][3] = 16'd4;
      run_move(2'd1, lat);
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL right_board: row2=%0d,%0d,%0d,%0d want 0,0,4,4", mout[2][0], mout[2][1], mout[2][2], mout[2][3]); end
      checks++; if (score_add !== 20'd4) begin errors++; $display("FAIL right_score: got %0d want 4", score_add); end
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL right_moved: got %b want 1", moved); end
   endtask

   task automatic test_vertical();
      clear_boards();
      mat[1][0] = 16'd4; mat[3][0] = 16'd4;
      exp_b[0][0] = 16'd8;
      run_move(2'd2, lat);
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL up_board: col0=%0d,%0d,%0d,%0d want 8,0,0,0", mout[0][0], mout[1][0], mout[2][0], mout[3][0]); end
      checks++; if (score_add !== 20'd8) begin errors++; $display("FAIL up_score: got %0d want 8", score_add); end
      clear_boards();
      mat[0][3] = 16'd2; mat[1][3] = 16'd2; mat[2][1] = 16'd8;
      exp_b[3][3] = 16'd4; exp_b[3][1] = 16'd8;
      run_move(2'd3, lat);
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL down_board: %0d cells wrong, col3 bottom=%0d want 4", board_diff(), mout[3][3]); end
      checks++; if (score_add !== 20'd4) begin errors++; $display("FAIL down_score: got %0d want 4", score_add); end
   endtask

   task automatic test_no_move();
      clear_boards();
      mat[0][0] = 16'd2;  mat[0][1] = 16'd4;
      mat[1][0] = 16'd8;  mat[1][1] = 16'd2;
      mat[2][0] = 16'd16;
      exp_b = mat;
      run_move(2'd0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL no_move_done: latency got %0d want 4", lat); end
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL no_move_board: %0d cells changed, want 0", board_diff()); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL no_move_moved: got %b want 0", moved); end
      checks++; if (score_add !== 20'd0) begin errors++; $display("FAIL no_move_score: got %0d want 0", score_add); end
      clear_boards();
      mat[0][0] = 16'd32768; mat[0][1] = 16'd32768;
      exp_b = mat;
      run_move(2'd0, lat);
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL max_tile_board: row0=%0d,%0d want 32768,32768", mout[0][0], mout[0][1]); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL max_tile_moved: got %b want 0", moved); end
      checks++; if (score_add !== 20'd0) begin errors++; $display("FAIL max_tile_score: got %0d want 0", score_add); end
   endtask

   task automatic test_back_to_back();
      clear_boards();
      mat[0][0] = 16'd2; mat[0][1] = 16'd2; mat[0][2] = 16'd4; mat[0][3] = 16'd4;
      exp_b[0][0] = 16'd4; exp_b[0][1] = 16'd8;
      @(negedge clk);
      dir = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      // Second board and direction while busy; start held across edges k+1..k+3.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mat[r][c] = 16'd2;
      dir = 2'd1;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      start = 1'b0;
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignore_start_done: got %b want 1", done); end
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL ignore_start_board: %0d cells wrong", board_diff()); end
      checks++; if (score_add !== 20'd12) begin errors++; $display("FAIL ignore_start_score: got %0d want 12", score_add); end
      // Start during the done cycle is accepted.
      clear_boards();
      mat[3][0] = 16'd4; mat[3][1] = 16'd4;
      exp_b[3][0] = 16'd8;
      dir = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL b2b_board: row3=%0d,%0d want 8,0", mout[3][0], mout[3][1]); end
      checks++; if (score_add !== 20'd8) begin errors++; $display("FAIL b2b_score: got %0d want 8", score_add); end
   endtask

   task automatic test_reset_mid_move();
      int seen;
      clear_boards();
      mat[0][0] = 16'd2; mat[0][3] = 16'd2;
      @(negedge clk);
      dir = 2'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      clear_boards();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      checks++; if (board_diff() !== 0) begin errors++; $display("FAIL mid_reset_board: %0d cells nonzero", board_diff()); end
      checks++; if (score_add !== 20'd0 || moved !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: score %0d moved %b want 0 0", score_add, moved); end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d active cycles want 0", seen); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; dir = 2'd0;
      clear_boards();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_left_pairs();
      test_left_four();
      test_right();
      test_vertical();
      test_no_move();
      test_back_to_back();
      test_reset_mid_move();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
